// File: rtl/spi_slave_port.sv
// SPI mode-0 slave with a 3-bit-address CPU register port.
// SCLK, SS_n and MOSI are oversampled in the clk domain. A single tx holding
// register and a single rx holding register sit between the CPU and the
// shifters. Status flags drive a registered, maskable interrupt.
module spi_slave_port #(
    parameter int DATABITS    = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        spi_select,
    input  logic [2:0]  mem_addr,
    input  logic        read_n,
    input  logic        write_n,
    input  logic [15:0] data_from_cpu,
    output logic [15:0] data_to_cpu,
    output logic        irq,
    input  logic        SCLK,
    input  logic        SS_n,
    input  logic        MOSI,
    output logic        MISO,
    output logic        MISO_oe
);

    localparam int            CW        = $clog2(DATABITS);
    localparam logic [CW-1:0] LAST_BIT  = CW'(DATABITS - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [2:0]    ADDR_RX   = 3'd0;
    localparam logic [2:0]    ADDR_TX   = 3'd1;
    localparam logic [2:0]    ADDR_STAT = 3'd2;
    localparam logic [2:0]    ADDR_CTRL = 3'd3;
    localparam logic [15:0]   CTRL_MASK = 16'h01DC;

    logic [SYNC_STAGES-1:0] sclk_pipe, ss_pipe, mosi_pipe;
    logic                   sclk_sync, ss_n_sync, mosi_sync;
    logic                   sclk_dly, ss_dly;
    logic                   sclk_rise, sclk_fall, ss_fall, ss_rise, selected;

    logic                   rd_prev, wr_prev, rd_stb, wr_stb;
    logic                   wr_tx, wr_status, wr_ctrl, rd_rx;

    logic [CW-1:0]          bitcnt;
    logic [DATABITS-1:0]    rx_shift, rx_next, rx_holding;
    logic [DATABITS-1:0]    tx_shift, tx_holding;
    logic                   tx_primed;
    logic                   frame_done, load_tx;

    logic                   rrdy, roe, toe, tur;
    logic [15:0]            ctrl, status_word, rd_mux;

    // Input synchronisers; idle levels match a deselected bus
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_pipe <= '0;
            ss_pipe   <= '1;
            mosi_pipe <= '0;
        end else begin
            sclk_pipe <= {sclk_pipe[SYNC_STAGES-2:0], SCLK};
            ss_pipe   <= {ss_pipe[SYNC_STAGES-2:0], SS_n};
            mosi_pipe <= {mosi_pipe[SYNC_STAGES-2:0], MOSI};
        end
    end

    assign sclk_sync = sclk_pipe[SYNC_STAGES-1];
    assign ss_n_sync = ss_pipe[SYNC_STAGES-1];
    assign mosi_sync = mosi_pipe[SYNC_STAGES-1];

    // Delayed copies for edge detection, and CPU strobe history
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_dly <= 1'b0;
            ss_dly   <= 1'b1;
            rd_prev  <= 1'b0;
            wr_prev  <= 1'b0;
        end else begin
            sclk_dly <= sclk_sync;
            ss_dly   <= ss_n_sync;
            rd_prev  <= rd_stb;
            wr_prev  <= wr_stb;
        end
    end

    assign selected  = ~ss_n_sync;
    assign sclk_rise = sclk_sync & ~sclk_dly;
    assign sclk_fall = ~sclk_sync & sclk_dly;
    assign ss_fall   = ss_dly & ~ss_n_sync;
    assign ss_rise   = ~ss_dly & ss_n_sync;

    // Accesses last two cycles; only the first cycle acts
    assign rd_stb    = spi_select & ~read_n & ~rd_prev;
    assign wr_stb    = spi_select & ~write_n & ~wr_prev;
    assign wr_tx     = wr_stb & (mem_addr == ADDR_TX);
    assign wr_status = wr_stb & (mem_addr == ADDR_STAT);
    assign wr_ctrl   = wr_stb & (mem_addr == ADDR_CTRL);
    assign rd_rx     = rd_stb & (mem_addr == ADDR_RX);

    assign rx_next    = {rx_shift[DATABITS-2:0], mosi_sync};
    assign frame_done = ~ss_fall & sclk_rise & selected & (bitcnt == LAST_BIT);
    // The tx shifter takes a new word at select and after every full frame
    assign load_tx    = ss_fall | frame_done;

    // Serial shifters and bit counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bitcnt     <= '0;
            rx_shift   <= '0;
            rx_holding <= '0;
            tx_shift   <= '0;
        end else begin
            if (load_tx)
                tx_shift <= tx_primed ? tx_holding : '0;
            if (ss_fall) begin
                bitcnt   <= '0;
                rx_shift <= '0;
            end else if (sclk_rise && selected) begin
                rx_shift <= rx_next;
                if (bitcnt == LAST_BIT) begin
                    bitcnt     <= '0;
                    rx_holding <= rx_next;
                end else begin
                    bitcnt <= bitcnt + CNT_ONE;
                end
            end else if (sclk_fall && selected && bitcnt != '0) begin
                tx_shift <= {tx_shift[DATABITS-2:0], 1'b0};
            end else if (ss_rise) begin
                bitcnt <= '0;
            end
        end
    end

    // tx holding register and status flags; a set beats a same-cycle clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_holding <= '0;
            tx_primed  <= 1'b0;
            rrdy       <= 1'b0;
            roe        <= 1'b0;
            toe        <= 1'b0;
            tur        <= 1'b0;
        end else begin
            if (wr_tx && !tx_primed) begin
                tx_holding <= data_from_cpu[DATABITS-1:0];
                tx_primed  <= 1'b1;
            end else if (load_tx) begin
                tx_primed  <= 1'b0;
            end
            toe  <= (wr_tx & tx_primed) | (toe & ~wr_status);
            tur  <= (load_tx & ~tx_primed) | (tur & ~wr_status);
            roe  <= (frame_done & rrdy) | (roe & ~wr_status);
            rrdy <= frame_done | (rrdy & ~(wr_status | rd_rx));
        end
    end

    // Status layout and read multiplexer
    always_comb begin
        status_word    = '0;
        status_word[8] = toe | roe | tur;
        status_word[7] = rrdy;
        status_word[6] = ~tx_primed;
        status_word[5] = ~tx_primed & ss_n_sync;
        status_word[4] = toe;
        status_word[3] = roe;
        status_word[2] = tur;
        rd_mux = '0;
        case (mem_addr)
            ADDR_RX:   rd_mux[DATABITS-1:0] = rx_holding;
            ADDR_STAT: rd_mux = status_word;
            ADDR_CTRL: rd_mux = ctrl;
            default:   rd_mux = '0;
        endcase
    end

    // Control register, registered read data and interrupt
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl        <= '0;
            data_to_cpu <= '0;
            irq         <= 1'b0;
        end else begin
            if (wr_ctrl)
                ctrl <= data_from_cpu & CTRL_MASK;
            data_to_cpu <= rd_mux;
            irq         <= |(status_word & ctrl);
        end
    end

    assign MISO    = tx_shift[DATABITS-1];
    assign MISO_oe = ~ss_n_sync;

endmodule

// File: tb/tb_spi_slave_port.sv
// Randomised bench for spi_slave_port with a transaction-level model and a
// queue-based scoreboard for CPU reads and MISO frames.
module tb_spi_slave_port;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        spi_select = 1'b0;
    logic [2:0]  mem_addr = '0;
    logic        read_n = 1'b1;
    logic        write_n = 1'b1;
    logic [15:0] data_from_cpu = '0;
    logic [15:0] data_to_cpu;
    logic        irq;
    logic        SCLK = 1'b0;
    logic        SS_n = 1'b1;
    logic        MOSI = 1'b0;
    logic        MISO;
    logic        MISO_oe;

    always #5 clk = ~clk;

    spi_slave_port #(.DATABITS(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset_n(reset_n), .spi_select(spi_select), .mem_addr(mem_addr),
        .read_n(read_n), .write_n(write_n), .data_from_cpu(data_from_cpu),
        .data_to_cpu(data_to_cpu), .irq(irq), .SCLK(SCLK), .SS_n(SS_n),
        .MOSI(MOSI), .MISO(MISO), .MISO_oe(MISO_oe)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit          m_primed, m_rrdy, m_roe, m_toe, m_tur;
    logic [7:0]  m_txh, m_rxh;
    logic [15:0] m_ctrl;

    // Scoreboard queues
    logic [15:0] exp_rd_q[$];
    string       exp_rd_name[$];
    logic [7:0]  exp_miso_q[$];
    logic [7:0]  act_miso_q[$];
    logic [7:0]  mosi_buf[4];

    logic rd_first = 1'b0;
    logic mon_rd_p = 1'b0;
    always @(posedge clk) mon_rd_p <= rd_first;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] m_status();
        logic [15:0] s;
        s    = '0;
        s[8] = m_toe | m_roe | m_tur;
        s[7] = m_rrdy;
        s[6] = !m_primed;
        s[5] = !m_primed;   // status is only read with SS_n idle
        s[4] = m_toe;
        s[3] = m_roe;
        s[2] = m_tur;
        return s;
    endfunction

    task automatic m_reset();
        m_primed = 0; m_rrdy = 0; m_roe = 0; m_toe = 0; m_tur = 0;
        m_txh = '0; m_rxh = '0; m_ctrl = '0;
    endtask

    // The slave takes the next word to send: the primed word, or zeros on underrun
    task automatic m_take(output logic [7:0] v);
        if (m_primed) begin
            v = m_txh;
            m_primed = 0;
        end else begin
            v = '0;
            m_tur = 1;
        end
    endtask

    // Monitor: compares reads and finished MISO frames against expectations
    always @(negedge clk) begin
        if (mon_rd_p) begin
            if (exp_rd_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_read: got 0x%04h expected none", data_to_cpu);
            end else begin
                check(exp_rd_name.pop_front(), data_to_cpu, exp_rd_q.pop_front());
            end
        end
        while (act_miso_q.size() > 0) begin
            if (exp_miso_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_frame: got 0x%02h expected none", act_miso_q.pop_front());
            end else begin
                check("miso_frame", {8'h00, act_miso_q.pop_front()}, {8'h00, exp_miso_q.pop_front()});
            end
        end
    end

    task automatic cpu_read(input logic [2:0] a);
        logic [15:0] e;
        @(negedge clk);
        case (a)
            3'd0:    e = {8'h00, m_rxh};
            3'd2:    e = m_status();
            3'd3:    e = m_ctrl;
            default: e = '0;
        endcase
        if (a == 3'd0) m_rrdy = 0;
        exp_rd_q.push_back(e);
        exp_rd_name.push_back($sformatf("read_addr%0d", a));
        spi_select = 1'b1; read_n = 1'b0; mem_addr = a; rd_first = 1'b1;
        @(negedge clk);
        rd_first = 1'b0;
        @(negedge clk);
        spi_select = 1'b0; read_n = 1'b1;
    endtask

    task automatic cpu_write(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        case (a)
            3'd1: if (!m_primed) begin m_txh = d[7:0]; m_primed = 1; end else m_toe = 1;
            3'd2: begin m_rrdy = 0; m_roe = 0; m_toe = 0; m_tur = 0; end
            3'd3: m_ctrl = d & 16'h01DC;
            default: ;
        endcase
        spi_select = 1'b1; write_n = 1'b0; mem_addr = a; data_from_cpu = d;
        @(negedge clk);
        @(negedge clk);
        spi_select = 1'b0; write_n = 1'b1;
    endtask

    // One SS_n window of nbits SCLK cycles at clk/8; mosi_buf supplies the bytes
    task automatic spi_xfer(input int nbits);
        logic [7:0] cur, cap;
        int nfull;
        nfull = nbits / 8;
        m_take(cur);
        for (int f = 0; f < nfull; f++) begin
            exp_miso_q.push_back(cur);
            if (m_rrdy) m_roe = 1;
            m_rrdy = 1;
            m_rxh = mosi_buf[f];
            m_take(cur);
        end
        cap = '0;
        @(negedge clk);
        SS_n = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            MOSI = mosi_buf[i / 8][7 - (i % 8)];
            repeat (4) @(negedge clk);
            cap = {cap[6:0], MISO};
            SCLK = 1'b1;
            repeat (4) @(negedge clk);
            SCLK = 1'b0;
            if (i % 8 == 7) act_miso_q.push_back(cap);
        end
        MOSI = 1'b0;
        repeat (4) @(negedge clk);
        SS_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic check_irq();
        repeat (2) @(negedge clk);
        check("irq", {15'b0, irq}, {15'b0, |(m_status() & m_ctrl)});
    endtask

    task automatic reset_mid_frame();
        mosi_buf[0] = 8'($urandom);
        @(negedge clk);
        SS_n = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            MOSI = mosi_buf[0][7 - i];
            repeat (4) @(negedge clk);
            SCLK = 1'b1;
            repeat (4) @(negedge clk);
            SCLK = 1'b0;
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b0; SS_n = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
        #1;
        check("rst_miso", {15'b0, MISO}, 16'h0000);
        check("rst_miso_oe", {15'b0, MISO_oe}, 16'h0000);
        check("rst_irq", {15'b0, irq}, 16'h0000);
        check("rst_data_to_cpu", data_to_cpu, 16'h0000);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        m_reset();
        @(negedge clk);
        check("post_rst_miso", {15'b0, MISO}, 16'h0000);
        cpu_read(3'd2);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0] a;
        m_reset();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("reset_data_to_cpu", data_to_cpu, 16'h0000);
        check("reset_irq", {15'b0, irq}, 16'h0000);
        check("reset_miso", {15'b0, MISO}, 16'h0000);
        check("reset_miso_oe", {15'b0, MISO_oe}, 16'h0000);
        cpu_read(3'd2);

        // Basic frame
        cpu_write(3'd1, 16'h00A5);
        mosi_buf[0] = 8'h3C;
        spi_xfer(8);
        cpu_read(3'd2);
        cpu_read(3'd0);
        cpu_read(3'd2);

        // Underrun with TUR interrupt enabled
        cpu_write(3'd2, 16'h0000);
        cpu_write(3'd3, 16'h0004);
        check_irq();
        mosi_buf[0] = 8'h5A;
        spi_xfer(8);
        check_irq();
        cpu_read(3'd2);
        cpu_read(3'd3);

        // Overrun, then status write clears flags
        cpu_write(3'd3, 16'h0000);
        mosi_buf[0] = 8'h11; spi_xfer(8);
        mosi_buf[0] = 8'h22; spi_xfer(8);
        cpu_read(3'd2);
        cpu_read(3'd0);
        cpu_write(3'd2, 16'hFFFF);
        cpu_read(3'd2);

        // Double tx write: overflow, first word is sent
        cpu_write(3'd1, 16'h0055);
        cpu_write(3'd1, 16'h0066);
        cpu_read(3'd2);
        mosi_buf[0] = 8'hC3; spi_xfer(8);

        // Two frames in one select window
        cpu_write(3'd1, 16'h00E7);
        mosi_buf[0] = 8'h01; mosi_buf[1] = 8'h02;
        spi_xfer(16);
        cpu_read(3'd2);
        cpu_read(3'd0);

        // Aborted partial frame, then a full one
        cpu_write(3'd2, 16'h0000);
        mosi_buf[0] = 8'hFF; spi_xfer(5);
        cpu_read(3'd2);
        cpu_read(3'd0);
        mosi_buf[0] = 8'h81; spi_xfer(8);
        cpu_read(3'd0);

        // Reset in the middle of a frame with interrupts live
        cpu_write(3'd3, 16'hFFFF);
        check_irq();
        reset_mid_frame();
        cpu_write(3'd1, 16'h00A5);
        mosi_buf[0] = 8'h3C; spi_xfer(8);
        cpu_read(3'd0);
        cpu_read(3'd2);

        // Randomised traffic
        for (int n = 0; n < 80; n++) begin
            a = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 6))
                0: cpu_write(3'd1, 16'($urandom));
                1: cpu_read(a);
                2: cpu_write(a, 16'($urandom));
                3: begin
                    for (int k = 0; k < 4; k++) mosi_buf[k] = 8'($urandom);
                    spi_xfer($urandom_range(1, 20));
                end
                4: check_irq();
                5: cpu_read(3'd2);
                default: cpu_read(3'd0);
            endcase
        end
        check_irq();

        repeat (10) @(negedge clk);
        check("pending_reads", 16'(exp_rd_q.size()), 16'h0000);
        check("pending_frames", 16'(exp_miso_q.size()), 16'h0000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_slave_port.md
Name: spi_slave_port

Overview:
- SPI slave (mode 0: CPOL=0, CPHA=0, MSB first), the far end of the team's EPCS/SPI master.
- Lets a peripheral FPGA answer an external SPI master through the same 3-bit-address CPU register port style.
- Asynchronous SCLK/SS_n/MOSI are oversampled in the clk domain: 2-flop synchronisers plus edge detection.
- One tx holding register and one rx holding register, with status flags and a registered interrupt.

Parameters:
- DATABITS, 8: bits per SPI frame; supported range 4..16.
- SYNC_STAGES, 2: synchroniser depth for SCLK, SS_n and MOSI; minimum 2.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset
- spi_select  in  1  CPU chip select
- mem_addr  in  3  register address
- read_n  in  1  read request, active-low
- write_n  in  1  write request, active-low
- data_from_cpu  in  16  write data
- data_to_cpu  out  16  registered read data
- irq  out  1  registered interrupt, active-high
- SCLK  in  1  SPI clock from the external master
- SS_n  in  1  SPI select, active-low
- MOSI  in  1  serial data in
- MISO  out  1  serial data out
- MISO_oe  out  1  MISO output enable (1 = drive)

Behaviour:
- Reset: reset_n is asynchronous, active-low; clock is clk. All registers clear to 0; data_to_cpu=0, irq=0, MISO=0, MISO_oe=0. Synchronisers reset to idle (SCLK=0, SS_n=1, MOSI=0).
- CPU access:
  - Read and write are two-cycle events. A strobe fires on the first cycle of spi_select & ~read_n (or ~write_n) and is suppressed in the following cycle.
  - Write takes effect at the clock edge ending the first cycle.
  - data_to_cpu is registered from mem_addr every cycle: 1-clk latency.
- Register map:
  - 0 rxdata, r: rx_holding zero-extended. A read strobe clears RRDY.
  - 1 txdata, w: data_from_cpu[DATABITS-1:0] goes to tx_holding.
  - 2 status, r; any write clears TOE/ROE/TUR/RRDY. Bits: 8 E=TOE|ROE|TUR, 7 RRDY, 6 TRDY=~tx_primed, 5 TMT=~tx_primed&ss_n_sync, 4 TOE, 3 ROE, 2 TUR.
  - 3 control, r/w: interrupt enables at the same bit positions (8,7,6,4,3,2). Others read 0.
  - 4–7: read 0; writes ignored.
- irq: registered OR of each (flag & enable), so it lags the flag by 1 clk.
- txdata write:
  - If tx_primed=0: load tx_holding, set tx_primed.
  - Else: TOE=1 and the data is dropped. This holds even if the shifter consumes tx_holding in the same cycle.
- Serial engine (synchronised signals; rising/falling detected on the sclk_sync delayed copy):
  - SS_n falling:
    - bitcnt=0, rx_shift=0.
    - tx_shift loads tx_holding and tx_primed clears.
    - If tx_primed=0: tx_shift loads all zeros and TUR=1.
  - SCLK rising while selected:
    - rx_shift={rx_shift[DATABITS-2:0],mosi_sync}; bitcnt++.
    - When bitcnt==DATABITS-1:
      - rx_holding gets the shifted value; RRDY=1; if RRDY already 1, also ROE=1.
      - bitcnt=0.
      - tx_shift reloads from tx_holding exactly as on SS_n falling (underrun rule included).
  - SCLK falling while selected and bitcnt!=0: tx_shift shifts left one bit, zero fill.
  - SS_n rising:
    - Partial frame discarded: no RRDY, no rx_holding update, bitcnt=0.
    - tx_primed is left unchanged if it was not consumed.
  - SCLK edges while deselected are ignored.
- Outputs: MISO=tx_shift[DATABITS-1]; MISO_oe=~ss_n_sync.
- Timing:
  - Each SCLK phase must last at least SYNC_STAGES+2 clk cycles; at the defaults, SCLK ≤ clk/8.
  - MISO updates SYNC_STAGES+1 clk cycles after the pin-level SCLK falling edge.
- Simultaneous events:
  - Flag set and clear in the same cycle (rxdata read or status write): the set wins.
  - Status write and a new byte in the same cycle: RRDY=1, ROE unchanged from the set rule.
  - Control write takes effect next cycle.
- Reset mid-frame: all state cleared; the master sees MISO=0 until the next SS_n falling edge.

Test Plan:
- Write txdata=0xA5, then the master clocks 8 bits with MOSI=0x3C at clk/8 -> MISO shows 10100101; RRDY=1; rxdata reads 0x003C; RRDY=0 after the read.
- Two back-to-back frames with no CPU tx write before the second -> second frame MISO=0x00, TUR=1, status bit 8=1. With iTUR=1, irq rises 1 clk after TUR sets.
- Receive 2 frames (0x11, 0x22) without reading rxdata -> ROE=1, rxdata=0x22. A status write clears ROE/TUR/TOE/RRDY -> status reads 0x0060 with SS_n high.
- Two txdata writes (0x55, 0x66) while idle -> TOE=1, TRDY=0; the next frame transmits 0x55.
- SS_n deasserted after 5 SCLK rising edges -> RRDY stays 0, rx_holding unchanged. The next full frame with MOSI=0x81 yields rxdata=0x0081.
- Assert reset_n low mid-frame after 3 bits -> MISO=0, MISO_oe=0, irq=0, status reads 0x0060 from 2 clk after release; the next frame behaves as the first frame.
